// File: rtl/j1_wb_bridge_if.sv
// Wishbone classic-pipelined bus bundle between the J1 I/O bridge (master)
// and the I/O slave.
interface j1_wb_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack;
  logic          stall;

  modport master (
    output cyc, stb, we, adr, dat_o,
    input  dat_i, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o,
    output dat_i, ack, stall
  );
endinterface

// File: rtl/j1_wb_bridge.sv
// Turns one J1 I/O read/write into a single Wishbone pipelined cycle, stalling
// the CPU until ack, with an optional timeout that aborts hung cycles.
module j1_wb_bridge #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           io_rd,
  input  logic           io_wr,
  input  logic [AW-1:0]  io_addr,
  input  logic [DW-1:0]  io_dout,
  output logic [DW-1:0]  io_din,
  output logic           io_busy,
  output logic           io_err,
  j1_wb_bridge_if.master wb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        r_state;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat_o;
  logic [DW-1:0] r_din;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  wire w_req    = io_rd | io_wr;
  wire w_expire = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  // NOTE: every register here uses <= so all state updates read the
  // pre-edge values; the reset branch is synchronous to match the bus reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat_o <= '0;
      r_din   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr   <= io_addr;
            r_dat_o <= io_dout;
            r_we    <= io_wr;  // write wins when both are requested
            r_cnt   <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_expire) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            if (!r_we) r_din <= '1;
            r_state <= S_DONE;
          end else if (!wb.stall) begin
            r_stb   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack on the expiry edge still completes the cycle normally.
          if (wb.ack) begin
            r_cyc   <= 1'b0;
            if (!r_we) r_din <= wb.dat_i;
            r_state <= S_DONE;
          end else if (w_expire) begin
            r_cyc   <= 1'b0;
            r_err   <= 1'b1;
            if (!r_we) r_din <= '1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb.cyc   = r_cyc;
  assign wb.stb   = r_stb;
  assign wb.we    = r_we;
  assign wb.adr   = r_adr;
  assign wb.dat_o = r_dat_o;
  assign io_din   = r_din;
  assign io_err   = r_err;
  assign io_busy  = ((r_state == S_IDLE) && w_req) ||
                    (r_state == S_REQ) || (r_state == S_WAIT);

endmodule

// File: tb/tb_j1_wb_bridge.sv
// Bench for j1_wb_bridge: table of CPU transactions against a scripted slave,
// with expected completions queued at issue and compared at DONE.
module tb_j1_wb_bridge;

  logic        clk;
  logic        rst;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        io_busy;
  logic        io_err;

  j1_wb_bridge_if #(.AW(16), .DW(16)) wb_if ();

  j1_wb_bridge #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_din  (io_din),
    .io_busy (io_busy),
    .io_err  (io_err),
    .wb      (wb_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] rdata;
    int          stall;
    int          ack_dly;
    bit          no_ack;
    bit          junk_ack;
    logic [15:0] exp_din;
    bit          exp_err;
    int          exp_busy;
    int          exp_stb;
    bit          exp_we;
  } vec_t;

  typedef struct {
    logic [15:0] din;
    bit          err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] dout, input logic [15:0] rdata,
                              input int stall, input int ack_dly, input bit no_ack,
                              input bit junk_ack, input logic [15:0] exp_din,
                              input bit exp_err, input int exp_busy, input int exp_stb,
                              input bit exp_we);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.dout = dout; v.rdata = rdata;
    v.stall = stall; v.ack_dly = ack_dly; v.no_ack = no_ack; v.junk_ack = junk_ack;
    v.exp_din = exp_din; v.exp_err = exp_err; v.exp_busy = exp_busy;
    v.exp_stb = exp_stb; v.exp_we = exp_we;
    return v;
  endfunction

  task automatic run_txn(input int idx, input vec_t v);
    int   stall_left = v.stall;
    int   ack_left   = v.ack_dly;
    int   busy_n = 0, stb_n = 0, cyc_n = 0, we_bad = 0, adr_bad = 0, err_n = 0;
    bit   done = 1'b0;
    exp_t e;
    string tag = $sformatf("v%0d", idx);

    @(negedge clk);
    io_rd   = v.rd;
    io_wr   = v.wr;
    io_addr = v.addr;
    io_dout = v.dout;
    sb.push_back('{v.exp_din, v.exp_err});

    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      wb_if.ack   = 1'b0;
      wb_if.stall = 1'b0;
      wb_if.dat_i = 16'hDEAD;
      if (io_busy) busy_n++;
      if (wb_if.stb) stb_n++;
      if (io_err) err_n++;
      if (wb_if.cyc) begin
        cyc_n++;
        if (wb_if.we !== v.exp_we) we_bad++;
        if (wb_if.adr !== v.addr || wb_if.dat_o !== v.dout) adr_bad++;
      end
      if (wb_if.cyc && wb_if.stb) begin
        if (stall_left > 0) begin
          wb_if.stall = 1'b1;
          stall_left--;
        end
        if (v.junk_ack) wb_if.ack = 1'b1;
      end else if (wb_if.cyc && !v.no_ack) begin
        if (ack_left == 0) begin
          wb_if.ack   = 1'b1;
          wb_if.dat_i = v.rdata;
        end else begin
          ack_left--;
        end
      end
      if (!io_busy) begin
        done  = 1'b1;
        io_rd = 1'b0;
        io_wr = 1'b0;
        e = sb.pop_front();
        check({tag, "_din"}, io_din, e.din);
        check({tag, "_err_done"}, io_err, e.err);
        check({tag, "_cyc_done"}, wb_if.cyc, 1'b0);
      end
      @(negedge clk);
    end

    if (!done) begin
      check({tag, "_completion"}, 0, 1);
      io_rd = 1'b0;
      io_wr = 1'b0;
      void'(sb.pop_front());
    end
    check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
    check({tag, "_stb_cycles"}, stb_n, v.exp_stb);
    check({tag, "_cyc_cycles"}, cyc_n, v.exp_busy - 1);
    check({tag, "_we_stable"}, we_bad, 0);
    check({tag, "_adr_dat_stable"}, adr_bad, 0);
    check({tag, "_err_pulses"}, err_n, v.exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    //          rd wr addr     dout     rdata    stl ack noack junk exp_din  err busy stb we
    vecs[0] = mk(1, 0, 16'h0004, 16'h0000, 16'hBEEF, 0,   0, 0, 0, 16'hBEEF, 0, 3, 1, 0);
    vecs[1] = mk(0, 1, 16'h0010, 16'h1234, 16'h5555, 0,   0, 0, 0, 16'hBEEF, 0, 3, 1, 1);
    vecs[2] = mk(1, 0, 16'h0002, 16'h0000, 16'h0A5A, 3,   2, 0, 0, 16'h0A5A, 0, 8, 4, 0);
    vecs[3] = mk(1, 1, 16'h0020, 16'hCAFE, 16'h7777, 0,   0, 0, 0, 16'h0A5A, 0, 3, 1, 1);
    vecs[4] = mk(1, 0, 16'h0030, 16'h0000, 16'h9999, 0,   0, 1, 0, 16'hFFFF, 1, 9, 1, 0);
    vecs[5] = mk(1, 0, 16'h0040, 16'h0000, 16'h1357, 0,   0, 0, 0, 16'h1357, 0, 3, 1, 0);
    vecs[6] = mk(1, 0, 16'h0050, 16'h0000, 16'h2468, 4,   2, 0, 0, 16'h2468, 0, 9, 5, 0);
    vecs[7] = mk(0, 1, 16'h0060, 16'h5A5A, 16'h0000, 100, 0, 1, 0, 16'h2468, 1, 9, 8, 1);
    vecs[8] = mk(1, 0, 16'h0070, 16'h0000, 16'h3333, 2,   0, 0, 1, 16'h3333, 0, 5, 3, 0);

    rst = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0;
    wb_if.ack = 1'b0; wb_if.stall = 1'b0; wb_if.dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_cyc", wb_if.cyc, 1'b0);
    check("rst_stb", wb_if.stb, 1'b0);
    check("rst_we", wb_if.we, 1'b0);
    check("rst_adr", wb_if.adr, 16'h0000);
    check("rst_dat_o", wb_if.dat_o, 16'h0000);
    check("rst_din", io_din, 16'h0000);
    check("rst_err", io_err, 1'b0);
    check("rst_busy", io_busy, 1'b0);

    // Stray ack while idle must not start or complete anything.
    wb_if.ack = 1'b1; wb_if.dat_i = 16'h9999;
    @(negedge clk); #1;
    wb_if.ack = 1'b0;
    check("idle_ack_cyc", wb_if.cyc, 1'b0);
    check("idle_ack_din", io_din, 16'h0000);
    check("idle_ack_busy", io_busy, 1'b0);

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);
    check("sb_empty", sb.size(), 0);

    // Reset while waiting for ack, then a late ack after reset.
    @(negedge clk);
    io_rd = 1'b1; io_addr = 16'h0ABC; io_dout = 16'h4444;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (wb_if.cyc && !wb_if.stb) found = 1'b1;
    end
    check("rstwait_reached", found, 1'b1);
    io_rd = 1'b0;
    rst   = 1'b1;
    @(negedge clk); #1;
    check("rstwait_cyc", wb_if.cyc, 1'b0);
    check("rstwait_stb", wb_if.stb, 1'b0);
    check("rstwait_we", wb_if.we, 1'b0);
    check("rstwait_adr", wb_if.adr, 16'h0000);
    check("rstwait_dat_o", wb_if.dat_o, 16'h0000);
    check("rstwait_din", io_din, 16'h0000);
    check("rstwait_err", io_err, 1'b0);
    check("rstwait_busy", io_busy, 1'b0);
    rst = 1'b0;
    wb_if.ack = 1'b1; wb_if.dat_i = 16'h4321;
    @(negedge clk); #1;
    wb_if.ack = 1'b0;
    check("late_ack_din", io_din, 16'h0000);
    check("late_ack_cyc", wb_if.cyc, 1'b0);
    check("late_ack_busy", io_busy, 1'b0);
    check("late_ack_err", io_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/j1_wb_bridge.md
# j1_wb_bridge

Wishbone master stage sitting directly upstream of the I/O slave. It turns one J1 I/O read or write request into one Wishbone classic-pipelined single cycle (CYC/STB/WE/ADR/DAT, with STALL and ACK handshaking). It stalls the CPU until the cycle completes, returns read data, and aborts hung cycles with a timeout.

## Interface
- AW, 16: Wishbone/I/O address width.
- DW, 16: data width (J1 cell size).
- TIMEOUT, 255: cycles allowed in REQ+WAIT before abort; 0 disables the timeout.

- clk  in  1  bus clock (same as wb.clk); single clock domain.
- rst  in  1  synchronous, active-high reset (same as wb.rst).
- io_rd  in  1  CPU read request; held until io_busy is low.
- io_wr  in  1  CPU write request; held until io_busy is low.
- io_addr  in  AW  CPU I/O address.
- io_dout  in  DW  CPU write data.
- io_din  out  DW  read data, registered.
- io_busy  out  1  CPU stall, combinational.
- io_err  out  1  one-cycle pulse on timeout abort.
- wb_cyc, wb_stb, wb_we  out  1  Wishbone master controls, registered.
- wb_adr  out  AW  Wishbone address, registered.
- wb_dat_o  out  DW  Wishbone write data, registered.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack  in  1  slave acknowledge.
- wb_stall  in  1  slave pipeline stall.

## Operation
- FSM states:
  - IDLE: request detection (state after reset).
  - REQ: CYC=1, STB=1.
  - WAIT: CYC=1, STB=0.
  - DONE: one cycle; CYC=0, STB=0.
- IDLE, io_rd|io_wr high: latch io_addr into wb_adr and io_dout into wb_dat_o. Set wb_we=io_wr. If both requests are high, the write wins and the read is dropped. Clear the timeout counter and go to REQ.
- REQ: on an edge with wb_stall=0 the strobe is accepted; go to WAIT.
- WAIT: on wb_ack=1, capture wb_dat_i into io_din if the cycle is a read, and go to DONE.
  - A write leaves io_din unchanged.
- An ack seen in REQ or IDLE is a protocol violation and is ignored.
- DONE: go to IDLE. A request present in DONE is the same instruction and is not re-issued.
- wb_adr, wb_dat_o and wb_we stay stable from entry to REQ until the next request is latched.
- io_busy = (IDLE & (io_rd|io_wr)) | REQ | WAIT. It is low in DONE.
- Timeout (TIMEOUT>0):
  - The counter increments every cycle in REQ or WAIT and saturates. Its width is clog2(TIMEOUT+1).
  - When the counter equals TIMEOUT-1 with no accepting ack on that edge: drop CYC/STB, force io_din to all ones if the cycle is a read, pulse io_err in DONE, and go to DONE.
  - If an ack and the timeout expiry land on the same edge, the ack wins: normal completion, no error.
- Reset values: state IDLE; wb_cyc, wb_stb, wb_we 0; wb_adr, wb_dat_o 0; io_din 0; io_err 0; counter 0.
- Reset mid-cycle drops CYC/STB on the next edge. No completion is reported.

## Timing
- All outputs are registered except io_busy.
- Zero-wait slave (stall=0, ack one cycle after accept):
  - cycle 0: IDLE sees the request.
  - cycle 1: REQ.
  - cycle 2: WAIT, with ack.
  - cycle 3: DONE, io_din valid.
  - io_busy is high in cycles 0–2: 3 stall cycles per access.
- Each wb_stall cycle in REQ adds one cycle. Each cycle of ack delay in WAIT adds one cycle.
- io_din holds its value until the next read completes.
- At most one outstanding transaction; no back-to-back pipelining.

## Test plan
- Read, zero-wait slave returning 16'hBEEF: io_busy is high for exactly 3 cycles, STB is high for 1 cycle, io_din=16'hBEEF in DONE, and wb_we=0 throughout.
- Write io_addr=16'h0010, io_dout=16'h1234: wb_adr=16'h0010, wb_dat_o=16'h1234 and wb_we=1 are stable from REQ through WAIT; io_din is unchanged.
- wb_stall held high for 3 cycles in REQ: STB stays high for 4 cycles and io_busy is high for 6 cycles. Then hold ack off for 2 cycles in WAIT: io_busy is high for 8 cycles.
- Timeout test, TIMEOUT=8, slave never acks:
  - CYC drops after 8 cycles in REQ+WAIT.
  - io_err pulses once.
  - A read returns io_din=16'hFFFF.
  - The next request proceeds normally.
- io_rd and io_wr asserted together: exactly one Wishbone cycle, with wb_we=1.
- rst asserted in WAIT: next edge has CYC=STB=0, io_busy=0 and every output at its reset value. A late ack after reset is ignored.
